// File: rtl/uart_tx_unit.sv
// Memory-mapped UART transmitter: TXD byte FIFO, 8N1 framing, STAT/CON register.
// Define UART_TX_IRQ_EN to add the irq_en control bit and the empty/idle interrupt.
module uart_tx_unit #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [31:0] TXD_ADDR  = 32'h4000_0018;
  localparam logic [31:0] STAT_ADDR = 32'h4000_0020;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          tx_r, line_s;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wptr_r, rptr_r, occ_s;
  logic [4:0]    count_s;
  logic          empty_s, full_s, busy_s, baud_last_s;
  logic          push_req_s, push_ok_s, ovf_set_s, stat_rd_s, pop_s, ovf_r;
  logic [7:0]    head_s;
  logic          irq_en_s;
  logic          unused_wdata_s;

  assign unused_wdata_s = ^wdata[31:8];

  assign occ_s       = wptr_r - rptr_r;
  assign count_s     = 5'(occ_s);
  assign empty_s     = (wptr_r == rptr_r);
  assign full_s      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign head_s      = mem_r[rptr_r[AW-1:0]];
  assign busy_s      = (state_r != IDLE);
  assign baud_last_s = (baud_cnt_r == BAUD_LAST);

  // A full FIFO still takes a byte when the transmitter pops in the same cycle.
  assign push_req_s = wr && (addr == TXD_ADDR);
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign ovf_set_s  = push_req_s && full_s && !pop_s;
  assign stat_rd_s  = rd && (addr == STAT_ADDR);

  // FSM next-state, baud/bit counters, shift register and FIFO pop.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        baud_cnt_s = '0;
        bit_idx_s  = 3'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          baud_cnt_s = '0;
          bit_idx_s  = 3'd0;
          state_s    = DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_cnt_s = '0;
          shift_s    = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_cnt_s = '0;
          // Chain the next frame without an idle bit when data is waiting.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s    = IDLE;
        baud_cnt_s = '0;
        bit_idx_s  = 3'd0;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later into tx_r.
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      IDLE:    line_s = 1'b1;
      START:   line_s = 1'b0;
      DATA:    line_s = shift_r[0];
      STOP:    line_s = 1'b1;
      default: line_s = 1'b1;
    endcase
  end

  // FSM state, counters, shift register and serial output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      tx_r       <= line_s;
    end
  end

  // FIFO storage and wrap-bit pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r[AW-1:0]] <= wdata[7:0];
        wptr_r                <= wptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
    end
  end

  // Sticky overflow flag; a same-cycle overflow beats the clear-on-read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (stat_rd_s) begin
      ovf_r <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_r;

  // Interrupt enable, written through the STAT/CON address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_r <= 1'b0;
    end else if (wr && (addr == STAT_ADDR)) begin
      irq_en_r <= wdata[0];
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_en_r && empty_s && (state_r == IDLE);
`else
  assign irq_en_s = 1'b0;
  assign irq      = 1'b0;
`endif

  // Status read mux; reads zero unless STAT is selected.
  always_comb begin
    rdata = 32'd0;
    if (stat_rd_s) begin
      rdata = {23'd0, irq_en_s, count_s[3:0], ovf_r, empty_s, full_s, busy_s};
    end else begin
      rdata = 32'd0;
    end
  end

  assign uart_tx = tx_r;

endmodule
